song_recorder: RTL and testbench

//   Record-mode counterpart to the learn-mode player. Turns debounced presses on the 8 note buttons into
//   10-bit note words and writes them into the song memory. Learn mode later reads that memory back.

---
 rtl/song_recorder.sv | 158 +++++++++++++++
 tb/tb_song_recorder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/song_recorder.sv
// song_recorder
//   Record-mode front end for the song memory. Debounces presses on the eight
//   note buttons, turns each accepted one-hot press into a 10-bit note word
//   {buts[0],...,buts[7],octave} and writes it at consecutive addresses. A
//   recording is closed with the terminator word 10'h000, written either on
//   rec_stop or automatically once DEPTH-1 notes are stored.
// Ports
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_buts[7:0]              note buttons, active high, bit0 = lowest note
//   i_octave[1:0]            octave, sampled when a press is accepted
//   i_rec_start, i_rec_stop  begin a recording / end it with a terminator
//   o_wr_en                  one-cycle write strobe per memory word
//   o_wr_addr, o_wr_data     write address and word (held while o_wr_en=0)
//   o_busy                   recording in progress (until terminator written)
//   o_full                   DEPTH-1 notes stored, sticky until next start
//   o_song_len               notes in current/last recording, terminator excluded
module song_recorder #(
  parameter int ADDR_W     = 6,
  parameter int DEPTH      = 64,
  parameter int DEB_CYCLES = 200000,
  parameter int DEB_W      = 18
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [7:0]        i_buts,
  input  logic [1:0]        i_octave,
  input  logic              i_rec_start,
  input  logic              i_rec_stop,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [9:0]        o_wr_data,
  output logic              o_busy,
  output logic              o_full,
  output logic [ADDR_W-1:0] o_song_len
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_REL, S_WAIT_PRESS, S_DEBOUNCE, S_WRITE, S_TERM, S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_LEN = ADDR_W'(DEPTH - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  state_t              r_state;
  logic [7:0]          r_cand;
  logic [DEB_W-1:0]    r_cnt;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [9:0]          r_wr_data;
  logic                r_busy;
  logic                r_full;
  logic [ADDR_W-1:0]   r_song_len;

  logic                w_onehot;
  logic [9:0]          w_note;
  logic [ADDR_W-1:0]   w_len_next;

  // x & (x-1) clears the lowest set bit; zero result means at most one bit set
  assign w_onehot   = (i_buts != 8'd0) && ((i_buts & (i_buts - 8'd1)) == 8'd0);
  // Button order is reversed in the word: lowest note lands in the MSB
  assign w_note     = {r_cand[0], r_cand[1], r_cand[2], r_cand[3],
                       r_cand[4], r_cand[5], r_cand[6], r_cand[7], i_octave};
  assign w_len_next = r_song_len + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_cand     <= '0;
      r_cnt      <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_busy     <= 1'b0;
      r_full     <= 1'b0;
      r_song_len <= '0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          // stop wins over a simultaneous start
          if (i_rec_start && !i_rec_stop) begin
            r_state    <= S_WAIT_REL;
            r_song_len <= '0;
            r_wr_addr  <= '0;
            r_full     <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_WAIT_REL: begin
          if (i_rec_stop) begin
            r_state   <= S_TERM;
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_song_len;
            r_wr_data <= '0;
          end else if (i_buts == 8'd0) begin
            r_state <= S_WAIT_PRESS;
          end
        end
        S_WAIT_PRESS: begin
          if (i_rec_stop) begin
            r_state   <= S_TERM;
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_song_len;
            r_wr_data <= '0;
          end else if (w_onehot) begin
            r_cand  <= i_buts;
            r_cnt   <= '0;
            r_state <= S_DEBOUNCE;
          end
        end
        S_DEBOUNCE: begin
          if (i_buts != r_cand) begin
            r_state <= S_WAIT_PRESS;
          end else if (i_rec_stop) begin
            r_state   <= S_TERM;
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_song_len;
            r_wr_data <= '0;
          end else if (r_cnt == DEB_LAST) begin
            // Write is issued on entry to WRITE so the strobe is registered
            r_state    <= S_WRITE;
            r_wr_en    <= 1'b1;
            r_wr_addr  <= r_song_len;
            r_wr_data  <= w_note;
            r_song_len <= w_len_next;
            if (w_len_next == LAST_LEN) r_full <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WRITE: begin
          if (r_full) begin
            // back-to-back terminator into the reserved last word
            r_state   <= S_TERM;
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_song_len;
            r_wr_data <= '0;
          end else begin
            r_state <= S_WAIT_REL;
          end
        end
        S_TERM: begin
          r_state <= S_DONE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_wr_en    = r_wr_en;
  assign o_wr_addr  = r_wr_addr;
  assign o_wr_data  = r_wr_data;
  assign o_busy     = r_busy;
  assign o_full     = r_full;
  assign o_song_len = r_song_len;

endmodule

// File: tb/tb_song_recorder.sv
// tb_song_recorder
//   Directed scenarios followed by randomized recordings. The reference model
//   works at the level of whole button events: a press produces a note iff it
//   is one-hot, held for at least DEB_CYCLES+1 cycles and fewer than DEPTH-1
//   notes are stored; every recording closes with a zero word at song_len.
module tb_song_recorder;
  localparam int AW  = 2;
  localparam int DP  = 4;
  localparam int DEB = 4;
  localparam int DW  = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    buts = '0;
  logic [1:0]    octave = '0;
  logic          rec_start = 1'b0;
  logic          rec_stop = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [9:0]    wr_data;
  logic          busy;
  logic          full;
  logic [AW-1:0] song_len;

  song_recorder #(.ADDR_W(AW), .DEPTH(DP), .DEB_CYCLES(DEB), .DEB_W(DW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_buts(buts), .i_octave(octave),
    .i_rec_start(rec_start), .i_rec_stop(rec_stop),
    .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .o_busy(busy), .o_full(full), .o_song_len(song_len)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            c;
    logic [AW-1:0] a;
    logic [9:0]    d;
  } wr_t;

  wr_t wq[$];
  wr_t exq[$];
  wr_t mon_w;

  always @(negedge clk) begin
    if (wr_en) begin
      mon_w.c = cyc;
      mon_w.a = wr_addr;
      mon_w.d = wr_data;
      wq.push_back(mon_w);
    end
  end

  int checks = 0;
  int errors = 0;
  int last_t0 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [9:0] word(input logic [7:0] b, input logic [1:0] o);
    return {b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7], o};
  endfunction

  task automatic start_rec();
    buts = '0;
    rec_start = 1'b1;
    step();
    rec_start = 1'b0;
    step(2);
  endtask

  task automatic stop_rec();
    rec_stop = 1'b1;
    step();
    rec_stop = 1'b0;
    step(3);
  endtask

  task automatic press(input logic [7:0] b, input logic [1:0] o, input int l, input int gap);
    buts = b;
    octave = o;
    last_t0 = cyc;
    step(l);
    buts = '0;
    octave = 2'($urandom);
    step(gap);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_wr_en"}, 32'(wr_en), 0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
    chk({tag, "_wr_data"}, 32'(wr_data), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_full"}, 32'(full), 0);
    chk({tag, "_song_len"}, 32'(song_len), 0);
  endtask

  initial begin
    // reset state
    step(2);
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    step();

    // first note: latency, address and word format
    start_rec();
    chk("start_busy", 32'(busy), 1);
    wq.delete();
    press(8'h01, 2'b10, 6, 3);
    chk("n1_count", 32'(wq.size()), 1);
    if (wq.size() >= 1) begin
      chk("n1_latency", 32'(wq[0].c - last_t0), DEB + 1);
      chk("n1_addr", 32'(wq[0].a), 0);
      chk("n1_data", 32'(wq[0].d), 32'(10'b1000000010));
    end
    chk("n1_len", 32'(song_len), 1);

    // too short a press, then a chord: nothing recorded
    wq.delete();
    press(8'h80, 2'b00, 3, 3);
    chk("short_nowrite", 32'(wq.size()), 0);
    press(8'h05, 2'b01, 10, 3);
    chk("chord_nowrite", 32'(wq.size()), 0);
    chk("reject_len", 32'(song_len), 1);

    // long hold spanning several accept windows -> one write
    press(8'h10, 2'b01, 12, 3);
    chk("hold_count", 32'(wq.size()), 1);
    if (wq.size() >= 1) begin
      chk("hold_addr", 32'(wq[0].a), 1);
      chk("hold_data", 32'(wq[0].d), 32'(word(8'h10, 2'b01)));
    end

    // stop after two notes
    wq.delete();
    stop_rec();
    chk("stop_count", 32'(wq.size()), 1);
    if (wq.size() >= 1) begin
      chk("stop_term_addr", 32'(wq[0].a), 2);
      chk("stop_term_data", 32'(wq[0].d), 0);
    end
    chk("stop_len", 32'(song_len), 2);
    chk("stop_full", 32'(full), 0);
    chk("stop_busy", 32'(busy), 0);

    // fill the memory: three notes plus back-to-back terminator
    start_rec();
    wq.delete();
    press(8'h02, 2'b11, 6, 3);
    press(8'h40, 2'b00, 7, 4);
    press(8'h08, 2'b01, 5, 4);
    chk("full_count", 32'(wq.size()), 4);
    if (wq.size() == 4) begin
      chk("full_a0", 32'(wq[0].a), 0);
      chk("full_d0", 32'(wq[0].d), 32'(word(8'h02, 2'b11)));
      chk("full_a1", 32'(wq[1].a), 1);
      chk("full_d1", 32'(wq[1].d), 32'(word(8'h40, 2'b00)));
      chk("full_a2", 32'(wq[2].a), 2);
      chk("full_d2", 32'(wq[2].d), 32'(word(8'h08, 2'b01)));
      chk("full_term_addr", 32'(wq[3].a), 3);
      chk("full_term_data", 32'(wq[3].d), 0);
      chk("full_b2b", 32'(wq[3].c - wq[2].c), 1);
    end
    chk("full_flag", 32'(full), 1);
    chk("full_busy", 32'(busy), 0);
    chk("full_len", 32'(song_len), 3);
    wq.delete();
    press(8'h01, 2'b00, 6, 3);
    chk("done_nowrite", 32'(wq.size()), 0);

    // new start clears full; reset during debounce aborts silently
    start_rec();
    chk("restart_full", 32'(full), 0);
    chk("restart_busy", 32'(busy), 1);
    press(8'h04, 2'b10, 6, 3);
    buts = 8'h02;
    step(2);
    #2 rst_n = 1'b0;
    #1;
    chk_zero_outputs("async_rst");
    wq.delete();
    step();
    rst_n = 1'b1;
    buts = '0;
    step();
    press(8'h01, 2'b00, 6, 3);
    chk("post_rst_nowrite", 32'(wq.size()), 0);
    chk("post_rst_busy", 32'(busy), 0);

    // start and stop together in idle
    rec_start = 1'b1;
    rec_stop = 1'b1;
    step();
    rec_start = 1'b0;
    rec_stop = 1'b0;
    step();
    chk("startstop_busy", 32'(busy), 0);
    press(8'h01, 2'b00, 6, 3);
    chk("startstop_nowrite", 32'(wq.size()), 0);

    // randomized recordings against the event-level model
    for (int r = 0; r < 15; r++) begin
      int n;
      int nev;
      wr_t e;
      start_rec();
      wq.delete();
      exq.delete();
      n = 0;
      nev = $urandom_range(1, 6);
      for (int k = 0; k < nev; k++) begin
        logic [7:0] b;
        logic [1:0] o;
        int l;
        int i;
        int j;
        bit single;
        single = ($urandom_range(0, 3) != 0);
        i = $urandom_range(0, 7);
        j = (i + $urandom_range(1, 7)) % 8;
        b = single ? (8'h01 << i) : ((8'h01 << i) | (8'h01 << j));
        o = 2'($urandom);
        l = $urandom_range(1, 8);
        if (single && l >= DEB + 1 && n < DP - 1) begin
          e.c = 0;
          e.a = AW'(n);
          e.d = word(b, o);
          exq.push_back(e);
          n++;
        end
        press(b, o, l, $urandom_range(3, 5));
      end
      if (n < DP - 1) stop_rec();
      else step(2);
      e.c = 0;
      e.a = AW'(n);
      e.d = '0;
      exq.push_back(e);
      chk("rnd_count", 32'(wq.size()), 32'(exq.size()));
      for (int k = 0; k < exq.size() && k < wq.size(); k++) begin
        chk("rnd_addr", 32'(wq[k].a), 32'(exq[k].a));
        chk("rnd_data", 32'(wq[k].d), 32'(exq[k].d));
      end
      chk("rnd_len", 32'(song_len), 32'(n));
      chk("rnd_full", 32'(full), 32'(n == DP - 1));
      chk("rnd_busy", 32'(busy), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
